vga_timing_fetch: RTL and testbench

- Upstream of the virtual VGA screen model.
- Generates VGA raster timing (hs/vs/de) from parameterised porch and sync widths.
- Issues pixel read requests to a fixed-latency framebuffer.
- Emits sync signals and 8-bit R/G/B data aligned in the same cycle, ready to drive a screen or a physical DAC.

---
 rtl/vga_timing_fetch.sv | 145 ++++++++++++++
 tb/tb_vga_timing_fetch.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_fetch.sv
// VGA raster timing with framebuffer fetch. Read requests come straight from the
// raster counters; syncs, de and RGB leave together RD_LAT+1 clocks later.
module vga_timing_fetch #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   RD_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        fb_rd_en,
   output logic [15:0] fb_x,
   output logic [15:0] fb_y,
   input  logic [23:0] fb_rdata,
   output logic        hs_o,
   output logic        vs_o,
   output logic        de_o,
   output logic [7:0]  r_o,
   output logic [7:0]  g_o,
   output logic [7:0]  b_o,
   output logic        frame_start_o,
   output logic [15:0] frame_cnt_o
);
   localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   typedef struct packed {
      logic fs;
      logic vs;
      logic hs;
      logic de;
   } ctl_t;

   logic [15:0] h_cnt_q, h_cnt_d;
   logic [15:0] v_cnt_q, v_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   ctl_t        pipe_q [RD_LAT];
   ctl_t        pipe_d [RD_LAT];
   ctl_t        stage0_s;
   ctl_t        tail_s;
   logic        h_wrap_s;
   logic        v_wrap_s;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic        fs_q, fs_d;
   logic [23:0] rgb_q, rgb_d;

   // Stage-0 decode (forced idle while disabled), raster advance and frame count
   always_comb begin
      h_wrap_s    = (h_cnt_q == H_LAST);
      v_wrap_s    = (v_cnt_q == V_LAST);
      stage0_s.de = en && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      stage0_s.hs = en && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      stage0_s.vs = en && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      stage0_s.fs = en && (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
      h_cnt_d     = 16'd0;
      v_cnt_d     = 16'd0;
      frame_cnt_d = frame_cnt_q;
      if (en) begin
         if (h_wrap_s) begin
            h_cnt_d = 16'd0;
            if (v_wrap_s) begin
               v_cnt_d     = 16'd0;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
               v_cnt_d = v_cnt_q + 16'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 16'd1;
            v_cnt_d = v_cnt_q;
         end
      end else begin
         h_cnt_d = 16'd0;
         v_cnt_d = 16'd0;
      end
   end

   // Control delay line matching the framebuffer latency, then output stage load
   always_comb begin
      pipe_d[0] = stage0_s;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      tail_s = pipe_q[RD_LAT-1];
      de_d   = tail_s.de;
      fs_d   = tail_s.fs;
      hs_d   = tail_s.hs ? HS_POL : ~HS_POL;
      vs_d   = tail_s.vs ? VS_POL : ~VS_POL;
      rgb_d  = tail_s.de ? fb_rdata : 24'd0;
   end

   // State registers; reset also flushes anything still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q     <= 16'd0;
         v_cnt_q     <= 16'd0;
         frame_cnt_q <= 16'd0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
         end
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         de_q  <= 1'b0;
         fs_q  <= 1'b0;
         rgb_q <= 24'd0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         pipe_q      <= pipe_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         de_q        <= de_d;
         fs_q        <= fs_d;
         rgb_q       <= rgb_d;
      end
   end

   assign fb_rd_en      = stage0_s.de & ~rst;
   assign fb_x          = h_cnt_q;
   assign fb_y          = v_cnt_q;
   assign hs_o          = hs_q;
   assign vs_o          = vs_q;
   assign de_o          = de_q;
   assign frame_start_o = fs_q;
   assign r_o           = rgb_q[23:16];
   assign g_o           = rgb_q[15:8];
   assign b_o           = rgb_q[7:0];
   assign frame_cnt_o   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_fetch.sv
// Bench for vga_timing_fetch: two small-raster instances (RD_LAT=1 positive syncs,
// RD_LAT=3 negative syncs) against a raster-position reference model.
module tb_vga_timing_fetch;
   localparam int HT    = 14;
   localparam int VT    = 7;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic [7:0] x;
      logic [7:0] y;
   } px_t;
   localparam px_t IDLE = '0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic        fb_rd_en_a, hs_a, vs_a, de_a, frame_start_a;
   logic [15:0] fb_x_a, fb_y_a, frame_cnt_a;
   logic [23:0] fb_rdata_a;
   logic [7:0]  r_a, g_a, b_a;
   logic        fb_rd_en_b, hs_b, vs_b, de_b, frame_start_b;
   logic [15:0] fb_x_b, fb_y_b, frame_cnt_b;
   logic [23:0] fb_rdata_b;
   logic [7:0]  r_b, g_b, b_b;

   always #5 clk = ~clk;

   vga_timing_fetch #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .RD_LAT(1)) u_a (
      .clk(clk), .rst(rst), .en(en), .fb_rd_en(fb_rd_en_a), .fb_x(fb_x_a), .fb_y(fb_y_a),
      .fb_rdata(fb_rdata_a), .hs_o(hs_a), .vs_o(vs_a), .de_o(de_a), .r_o(r_a), .g_o(g_a),
      .b_o(b_a), .frame_start_o(frame_start_a), .frame_cnt_o(frame_cnt_a));

   vga_timing_fetch #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(3)) u_b (
      .clk(clk), .rst(rst), .en(en), .fb_rd_en(fb_rd_en_b), .fb_x(fb_x_b), .fb_y(fb_y_b),
      .fb_rdata(fb_rdata_b), .hs_o(hs_b), .vs_o(vs_b), .de_o(de_b), .r_o(r_b), .g_o(g_b),
      .b_o(b_b), .frame_start_o(frame_start_b), .frame_cnt_o(frame_cnt_b));

   // Framebuffer models: {x,y,0x5A} RD_LAT cycles after a request, noise otherwise
   logic [24:0] fpa [1];
   logic [24:0] fpb [3];
   logic [23:0] noise;
   always @(posedge clk) begin
      noise  <= 24'($urandom);
      fpa[0] <= {fb_rd_en_a, fb_x_a[7:0], fb_y_a[7:0], 8'h5A};
      fpb[0] <= {fb_rd_en_b, fb_x_b[7:0], fb_y_b[7:0], 8'h5A};
      fpb[1] <= fpb[0];
      fpb[2] <= fpb[1];
   end
   assign fb_rdata_a = (fpa[0][24] === 1'b1) ? fpa[0][23:0] : noise;
   assign fb_rdata_b = (fpb[2][24] === 1'b1) ? fpb[2][23:0] : noise;

   // Reference: raster position p -> (h,v) by division; outputs trail by RD_LAT+1
   function automatic px_t stage(input int p);
      px_t s;
      int  h, v;
      h    = p % HT;
      v    = p / HT;
      s.de = (h < 8) && (v < 4);
      s.hs = (h >= 10) && (h < 12);
      s.vs = (v == 5);
      s.fs = (p == 0);
      s.x  = 8'(h);
      s.y  = 8'(v);
      return s;
   endfunction

   function automatic logic [23:0] exp_rgb(input px_t e);
      return e.de ? {e.x, e.y, 8'h5A} : 24'd0;
   endfunction

   int  pos_m  = 0;
   int  fcnt_m = 0;
   px_t qa[$];
   px_t qb[$];
   px_t ea = IDLE;
   px_t eb = IDLE;
   always @(posedge clk) begin
      px_t s0;
      if (rst) begin
         pos_m = 0;
         fcnt_m = 0;
         qa.delete();
         qb.delete();
         qa.push_back(IDLE);
         repeat (3) qb.push_back(IDLE);
         ea = IDLE;
         eb = IDLE;
      end else begin
         s0 = en ? stage(pos_m) : IDLE;
         ea = qa.pop_front();
         qa.push_back(s0);
         eb = qb.pop_front();
         qb.push_back(s0);
         if (en) begin
            if (pos_m == FRAME - 1) fcnt_m = (fcnt_m + 1) % 65536;
            pos_m = (pos_m + 1) % FRAME;
         end else begin
            pos_m = 0;
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({hs_a, vs_a, de_a, frame_start_a} !== 4'b0000) begin
         bad++; $display("FAIL reset_ctl_a got=%b want=0000", {hs_a, vs_a, de_a, frame_start_a});
      end
      total++;
      if ({hs_b, vs_b, de_b, frame_start_b} !== 4'b1100) begin
         bad++; $display("FAIL reset_ctl_b got=%b want=1100", {hs_b, vs_b, de_b, frame_start_b});
      end
      total++;
      if ({r_a, g_a, b_a, r_b, g_b, b_b} !== 48'd0) begin
         bad++; $display("FAIL reset_rgb got=%h want=0", {r_a, g_a, b_a, r_b, g_b, b_b});
      end
      total++;
      if ({frame_cnt_a, frame_cnt_b, fb_rd_en_a, fb_rd_en_b} !== 34'd0) begin
         bad++; $display("FAIL reset_cnt_rd got=%h want=0", {frame_cnt_a, frame_cnt_b, fb_rd_en_a, fb_rd_en_b});
      end
   endtask

   task automatic test_timing();
      int first_de = -1;
      int first_fs = -1;
      int de_cnt   = 0;
      px_t s;
      rst = 1'b0;
      en  = 1'b1;
      for (int k = 1; k <= 104; k++) begin
         @(negedge clk);
         if (de_a === 1'b1 && first_de < 0) first_de = k;
         if (frame_start_a === 1'b1 && first_fs < 0) first_fs = k;
         if (k >= 2 && k < 2 + FRAME && de_a === 1'b1) de_cnt++;
         total++;
         if ({de_a, hs_a, vs_a, frame_start_a} !== {ea.de, ea.hs, ea.vs, ea.fs}) begin
            bad++; $display("FAIL timing_a cycle=%0d got=%b want=%b", k,
               {de_a, hs_a, vs_a, frame_start_a}, {ea.de, ea.hs, ea.vs, ea.fs});
         end
         s = stage(pos_m);
         total++;
         if (fb_rd_en_a !== s.de || (s.de && {fb_x_a, fb_y_a} !== {8'd0, s.x, 8'd0, s.y})) begin
            bad++; $display("FAIL req_a cycle=%0d got=%b/%0d/%0d want=%b/%0d/%0d", k,
               fb_rd_en_a, fb_x_a, fb_y_a, s.de, s.x, s.y);
         end
      end
      total++;
      if (first_de != 2) begin bad++; $display("FAIL first_de got=%0d want=2", first_de); end
      total++;
      if (first_fs != 2) begin bad++; $display("FAIL first_fs got=%0d want=2", first_fs); end
      total++;
      if (de_cnt != 32) begin bad++; $display("FAIL de_per_frame got=%0d want=32", de_cnt); end
   endtask

   task automatic test_data();
      bit found = 1'b0;
      for (int k = 0; k < 110; k++) begin
         @(negedge clk);
         total++;
         if ({r_a, g_a, b_a} !== exp_rgb(ea)) begin
            bad++; $display("FAIL data_a got=%h want=%h", {r_a, g_a, b_a}, exp_rgb(ea));
         end
         total++;
         if ({de_b, r_b, g_b, b_b} !== {eb.de, exp_rgb(eb)}) begin
            bad++; $display("FAIL data_b got=%h want=%h", {de_b, r_b, g_b, b_b}, {eb.de, exp_rgb(eb)});
         end
         if (eb.de && eb.x == 8'd7 && eb.y == 8'd2) begin
            found = 1'b1;
            total++;
            if ({de_b, r_b, g_b, b_b} !== {1'b1, 8'd7, 8'd2, 8'h5A}) begin
               bad++; $display("FAIL pixel_7_2 got=%h want=107025a", {de_b, r_b, g_b, b_b});
            end
         end
         if (de_b === 1'b0) begin
            total++;
            if ({r_b, g_b, b_b} !== 24'd0) begin
               bad++; $display("FAIL blank_rgb_b got=%h want=0", {r_b, g_b, b_b});
            end
         end
      end
      total++;
      if (!found) begin bad++; $display("FAIL pixel_7_2_seen got=0 want=1"); end
   endtask

   task automatic test_polarity();
      int hs_run = 0, vs_run = 0, hs_w = -1, vs_w = -1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({hs_b, vs_b} !== 2'b11) begin bad++; $display("FAIL pol_idle got=%b want=11", {hs_b, vs_b}); end
      rst = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (hs_b === 1'b0) hs_run++;
         else begin if (hs_run > 0 && hs_w < 0) hs_w = hs_run; hs_run = 0; end
         if (vs_b === 1'b0) vs_run++;
         else begin if (vs_run > 0 && vs_w < 0) vs_w = vs_run; vs_run = 0; end
         total++;
         if ({hs_b, vs_b} !== {~eb.hs, ~eb.vs}) begin
            bad++; $display("FAIL pol_b got=%b want=%b", {hs_b, vs_b}, {~eb.hs, ~eb.vs});
         end
      end
      total++;
      if (hs_w != 2) begin bad++; $display("FAIL hs_width got=%0d want=2", hs_w); end
      total++;
      if (vs_w != 14) begin bad++; $display("FAIL vs_width got=%0d want=14", vs_w); end
   endtask

   task automatic test_en_toggle();
      int          guard = 0;
      logic [15:0] fc0;
      logic [12:0] dha, fha, dhb, fhb;
      @(negedge clk);
      while (pos_m != HT + 3 && guard < 200) begin @(negedge clk); guard++; end
      total++;
      if (pos_m != HT + 3) begin bad++; $display("FAIL en_wait got=timeout want=h3v1"); end
      fc0 = frame_cnt_a;
      en  = 1'b0;
      #1;
      total++;
      if (fb_rd_en_a !== 1'b0) begin bad++; $display("FAIL en_rd_gate got=%b want=0", fb_rd_en_a); end
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         dha[j] = de_a; fha[j] = frame_start_a;
         dhb[j] = de_b; fhb[j] = frame_start_b;
         if (j == 5) en = 1'b1;
      end
      total++;
      if ({dha[1], dha[6:2], fha[6], fha[7]} !== 8'b1_00000_0_1) begin
         bad++; $display("FAIL en_drain_a got=%b want=10000001", {dha[1], dha[6:2], fha[6], fha[7]});
      end
      total++;
      if ({dhb[3], dhb[8:4], fhb[8], fhb[9]} !== 8'b1_00000_0_1) begin
         bad++; $display("FAIL en_drain_b got=%b want=10000001", {dhb[3], dhb[8:4], fhb[8], fhb[9]});
      end
      total++;
      if ({frame_cnt_a, frame_cnt_b} !== {fc0, fc0}) begin
         bad++; $display("FAIL en_fcnt got=%0d/%0d want=%0d", frame_cnt_a, frame_cnt_b, fc0);
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      logic [5:0] fsa, fsb, deb;
      while (pos_m != 2 * HT + 4 && guard < 200) begin @(negedge clk); guard++; end
      total++;
      if (pos_m != 2 * HT + 4) begin bad++; $display("FAIL rst_wait got=timeout want=h4v2"); end
      rst = 1'b1;
      #1;
      total++;
      if ({fb_rd_en_a, fb_rd_en_b} !== 2'b00) begin
         bad++; $display("FAIL rst_rd_gate got=%b want=00", {fb_rd_en_a, fb_rd_en_b});
      end
      @(negedge clk);
      total++;
      if ({de_a, de_b, r_a, g_a, b_a, r_b, g_b, b_b} !== 50'd0) begin
         bad++; $display("FAIL rst_mid_out got=%h want=0", {de_a, de_b, r_a, g_a, b_a, r_b, g_b, b_b});
      end
      total++;
      if ({hs_a, hs_b, frame_cnt_a} !== {1'b0, 1'b1, 16'd0}) begin
         bad++; $display("FAIL rst_mid_sync got=%h want=10000", {hs_a, hs_b, frame_cnt_a});
      end
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         fsa[k] = frame_start_a; fsb[k] = frame_start_b; deb[k] = de_b;
      end
      total++;
      if ({fsa[2:1], fsb[4:1], deb[3:1]} !== 9'b10_1000_000) begin
         bad++; $display("FAIL rst_restart got=%b want=101000000", {fsa[2:1], fsb[4:1], deb[3:1]});
      end
   endtask

   task automatic test_frames();
      int na = 0, nb = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 320; k++) begin
         @(negedge clk);
         if (frame_start_a === 1'b1) na++;
         if (frame_start_b === 1'b1) nb++;
      end
      total++;
      if (na != 4 || nb != 4) begin bad++; $display("FAIL fs_count got=%0d/%0d want=4", na, nb); end
      total++;
      if ({frame_cnt_a, frame_cnt_b} !== {16'd3, 16'd3}) begin
         bad++; $display("FAIL frame_cnt got=%0d/%0d want=3", frame_cnt_a, frame_cnt_b);
      end
   endtask

   task automatic test_random_en();
      px_t s;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         total++;
         if ({de_a, hs_a, vs_a, frame_start_a, r_a, g_a, b_a} !== {ea.de, ea.hs, ea.vs, ea.fs, exp_rgb(ea)}) begin
            bad++; $display("FAIL rnd_out_a got=%h want=%h", {de_a, hs_a, vs_a, frame_start_a, r_a, g_a, b_a},
               {ea.de, ea.hs, ea.vs, ea.fs, exp_rgb(ea)});
         end
         total++;
         if ({de_b, hs_b, vs_b, frame_start_b, r_b, g_b, b_b} !== {eb.de, ~eb.hs, ~eb.vs, eb.fs, exp_rgb(eb)}) begin
            bad++; $display("FAIL rnd_out_b got=%h want=%h", {de_b, hs_b, vs_b, frame_start_b, r_b, g_b, b_b},
               {eb.de, ~eb.hs, ~eb.vs, eb.fs, exp_rgb(eb)});
         end
         total++;
         if (frame_cnt_b !== 16'(fcnt_m)) begin
            bad++; $display("FAIL rnd_fcnt got=%0d want=%0d", frame_cnt_b, fcnt_m);
         end
         en = ($urandom_range(0, 15) != 0);
         #1;
         s = stage(pos_m);
         total++;
         if (fb_rd_en_b !== (en && s.de) || (fb_rd_en_b && {fb_x_b, fb_y_b} !== {8'd0, s.x, 8'd0, s.y})) begin
            bad++; $display("FAIL rnd_req_b got=%b/%0d/%0d want=%b/%0d/%0d", fb_rd_en_b, fb_x_b, fb_y_b,
               en && s.de, s.x, s.y);
         end
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_data();
      test_polarity();
      test_en_toggle();
      test_reset_mid();
      test_frames();
      test_random_en();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
